// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: memory geometry and FSM state encoding.
package program_loader_pkg;

    localparam int unsigned MEM_DEPTH = 16;
    localparam int unsigned WORD_W    = 8;
    localparam int unsigned ADDR_W    = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_RUN,
        ST_ERROR
    } state_t;

endpackage

// File: rtl/program_loader_mem.sv
// 16x8 program store: one synchronous write port, one combinational read port, synchronous clear.
module loader_mem
    import program_loader_pkg::*;
(
    input  logic              clock,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clock) begin
        if (clear) begin
            mem <= '{default: '0};
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/program_loader.sv
// Loads 16 program bytes from a valid/ready byte stream, optionally verifies a
// modulo-256 checksum, then releases the downstream processor from reset.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned CHECKSUM_EN    = 1,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clock,
    input  logic              reset_p,
    input  logic              load_start,
    input  logic              run_start,
    input  logic              rx_valid,
    input  logic [WORD_W-1:0] rx_data,
    output logic              rx_ready,
    input  logic [ADDR_W-1:0] rom_addr,
    output logic [WORD_W-1:0] rom_data,
    output logic              cpu_reset_p,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_error
);

    // Timeout fires on the idle cycle that would bring the gap count to TIMEOUT_CYCLES.
    localparam logic [7:0] GAP_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t            state, state_next;
    logic [ADDR_W-1:0] wr_ptr, wr_ptr_next;
    logic [WORD_W-1:0] sum, sum_next;
    logic [7:0]        gap, gap_next;
    logic              done_q, done_next;
    logic              cpu_reset_q;
    logic              accept;
    logic              mem_we;

    assign rx_ready   = (state == ST_LOAD) || (state == ST_CHECK);
    assign load_busy  = rx_ready;
    assign load_error = (state == ST_ERROR);
    assign load_done  = done_q;
    assign cpu_reset_p = cpu_reset_q;
    assign accept     = rx_valid && rx_ready;

    always_ff @(posedge clock) begin
        if (reset_p) begin
            state       <= ST_IDLE;
            wr_ptr      <= '0;
            sum         <= '0;
            gap         <= '0;
            done_q      <= 1'b0;
            cpu_reset_q <= 1'b1;
        end else begin
            state       <= state_next;
            wr_ptr      <= wr_ptr_next;
            sum         <= sum_next;
            gap         <= gap_next;
            done_q      <= done_next;
            cpu_reset_q <= (state != ST_RUN);
        end
    end

    always_comb begin
        state_next  = state;
        wr_ptr_next = wr_ptr;
        sum_next    = sum;
        gap_next    = gap;
        done_next   = 1'b0;
        mem_we      = 1'b0;

        if (load_start) begin
            // Restart wins over everything, including a byte accepted this cycle.
            state_next  = ST_LOAD;
            wr_ptr_next = '0;
            sum_next    = '0;
            gap_next    = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (run_start) begin
                        state_next = ST_RUN;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        mem_we      = 1'b1;
                        wr_ptr_next = wr_ptr + 4'd1;
                        sum_next    = sum + rx_data;
                        gap_next    = '0;
                        if (wr_ptr == 4'hF) begin
                            if (CHECKSUM_EN != 0) begin
                                state_next = ST_CHECK;
                            end else begin
                                state_next = ST_RUN;
                                done_next  = 1'b1;
                            end
                        end
                    end else if (gap == GAP_LAST) begin
                        state_next = ST_ERROR;
                    end else begin
                        gap_next = gap + 8'd1;
                    end
                end
                ST_CHECK: begin
                    if (accept) begin
                        gap_next = '0;
                        if (rx_data == sum) begin
                            state_next = ST_RUN;
                            done_next  = 1'b1;
                        end else begin
                            state_next = ST_ERROR;
                        end
                    end else if (gap == GAP_LAST) begin
                        state_next = ST_ERROR;
                    end else begin
                        gap_next = gap + 8'd1;
                    end
                end
                ST_RUN, ST_ERROR: begin
                    state_next = state;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    loader_mem u_mem (
        .clock   (clock),
        .clear   (reset_p),
        .wr_en   (mem_we),
        .wr_addr (wr_ptr),
        .wr_data (rx_data),
        .rd_addr (rom_addr),
        .rd_data (rom_data)
    );

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader (checksum and no-checksum builds).
module tb_program_loader;

    logic       clock = 1'b0;
    logic       reset_p = 1'b1;
    logic       load_start = 1'b0;
    logic       run_start = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [3:0] rom_addr = 4'h0;

    logic       rx_ready, cpu_reset_p, load_busy, load_done, load_error;
    logic [7:0] rom_data;
    logic       nc_rx_ready, nc_cpu_reset_p, nc_load_busy, nc_load_done, nc_load_error;
    logic [7:0] nc_rom_data;

    int checks = 0;
    int failures = 0;
    int done_total = 0;

    // Program image; its byte sum modulo 256 is 8'h9B.
    logic [7:0] prog [16];

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (load_done) done_total <= done_total + 1;
    end

    program_loader #(.CHECKSUM_EN(1), .TIMEOUT_CYCLES(8)) dut (
        .clock(clock), .reset_p(reset_p), .load_start(load_start), .run_start(run_start),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .rom_addr(rom_addr), .rom_data(rom_data), .cpu_reset_p(cpu_reset_p),
        .load_busy(load_busy), .load_done(load_done), .load_error(load_error)
    );

    program_loader #(.CHECKSUM_EN(0), .TIMEOUT_CYCLES(255)) dut_nc (
        .clock(clock), .reset_p(reset_p), .load_start(load_start), .run_start(run_start),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(nc_rx_ready),
        .rom_addr(rom_addr), .rom_data(nc_rom_data), .cpu_reset_p(nc_cpu_reset_p),
        .load_busy(nc_load_busy), .load_done(nc_load_done), .load_error(nc_load_error)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_p = 1'b1; load_start = 1'b0; run_start = 1'b0; rx_valid = 1'b0;
        tick();
        tick();
        reset_p = 1'b0;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_prog();
        for (int i = 0; i < 16; i++) send_byte(prog[i]);
    endtask

    task automatic test_reset();
        do_reset();
        rom_addr = 4'd5; #1;
        checks++; if (rx_ready !== 1'b0) begin failures++; $display("FAIL reset_rx_ready got=%b exp=0", rx_ready); end
        checks++; if (cpu_reset_p !== 1'b1) begin failures++; $display("FAIL reset_cpu_reset got=%b exp=1", cpu_reset_p); end
        checks++; if (load_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", load_busy); end
        checks++; if (load_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", load_done); end
        checks++; if (load_error !== 1'b0) begin failures++; $display("FAIL reset_error got=%b exp=0", load_error); end
        checks++; if (rom_data !== 8'h00) begin failures++; $display("FAIL reset_mem got=%h exp=00", rom_data); end
    endtask

    task automatic test_good_load();
        int d0;
        do_reset();
        d0 = done_total;
        start_load();
        checks++; if (load_busy !== 1'b1) begin failures++; $display("FAIL good_busy got=%b exp=1", load_busy); end
        send_prog();
        checks++; if (rx_ready !== 1'b1 || load_done !== 1'b0) begin failures++; $display("FAIL good_in_check ready=%b done=%b exp ready=1 done=0", rx_ready, load_done); end
        send_byte(8'h9B);
        checks++; if (load_done !== 1'b1) begin failures++; $display("FAIL good_done_pulse got=%b exp=1", load_done); end
        checks++; if (cpu_reset_p !== 1'b1) begin failures++; $display("FAIL good_cpu_reset_lag got=%b exp=1", cpu_reset_p); end
        tick();
        checks++; if (load_done !== 1'b0) begin failures++; $display("FAIL good_done_one_cycle got=%b exp=0", load_done); end
        checks++; if (cpu_reset_p !== 1'b0) begin failures++; $display("FAIL good_cpu_release got=%b exp=0", cpu_reset_p); end
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
        rom_addr = 4'd1; #1;
        checks++; if (rom_data !== 8'hF2) begin failures++; $display("FAIL good_rom1 got=%h exp=F2", rom_data); end
        rom_addr = 4'd2; #1;
        checks++; if (rom_data !== 8'h90) begin failures++; $display("FAIL good_rom2 got=%h exp=90", rom_data); end
        checks++; if (done_total - d0 !== 1) begin failures++; $display("FAIL good_done_count got=%0d exp=1", done_total - d0); end
        checks++; if (cpu_reset_p !== 1'b0 || load_busy !== 1'b0) begin failures++; $display("FAIL good_run_hold cpu=%b busy=%b exp 0 0", cpu_reset_p, load_busy); end
    endtask

    task automatic test_bad_checksum();
        do_reset();
        start_load();
        send_prog();
        send_byte(8'hA4);
        checks++; if (load_error !== 1'b1) begin failures++; $display("FAIL bad_error got=%b exp=1", load_error); end
        checks++; if (load_done !== 1'b0) begin failures++; $display("FAIL bad_done got=%b exp=0", load_done); end
        tick();
        checks++; if (cpu_reset_p !== 1'b1) begin failures++; $display("FAIL bad_cpu_reset got=%b exp=1", cpu_reset_p); end
        rom_addr = 4'd0; #1;
        checks++; if (rom_data !== 8'h19) begin failures++; $display("FAIL bad_rom0 got=%h exp=19", rom_data); end
        rom_addr = 4'd1; #1;
        checks++; if (rom_data !== 8'hF2) begin failures++; $display("FAIL bad_rom1 got=%h exp=F2", rom_data); end
    endtask

    task automatic test_timeout();
        do_reset();
        start_load();
        send_byte(8'h19);
        send_byte(8'hF2);
        send_byte(8'h90);
        repeat (7) tick();
        checks++; if (load_busy !== 1'b1 || load_error !== 1'b0) begin failures++; $display("FAIL timeout_early busy=%b err=%b exp 1 0", load_busy, load_error); end
        tick();
        checks++; if (load_error !== 1'b1) begin failures++; $display("FAIL timeout_error got=%b exp=1", load_error); end
        checks++; if (rx_ready !== 1'b0) begin failures++; $display("FAIL timeout_ready got=%b exp=0", rx_ready); end
    endtask

    task automatic test_restart();
        int d0;
        do_reset();
        d0 = done_total;
        start_load();
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44); send_byte(8'h55);
        // Byte offered alongside load_start must be dropped.
        rx_valid = 1'b1; rx_data = 8'h77; load_start = 1'b1;
        tick();
        rx_valid = 1'b0; load_start = 1'b0;
        send_prog();
        send_byte(8'h9B);
        tick();
        tick();
        checks++; if (load_error !== 1'b0 || cpu_reset_p !== 1'b0) begin failures++; $display("FAIL restart_state err=%b cpu=%b exp 0 0", load_error, cpu_reset_p); end
        for (int a = 0; a < 5; a++) begin
            rom_addr = 4'(a); #1;
            checks++; if (rom_data !== prog[a]) begin failures++; $display("FAIL restart_rom%0d got=%h exp=%h", a, rom_data, prog[a]); end
        end
        checks++; if (done_total - d0 !== 1) begin failures++; $display("FAIL restart_done_count got=%0d exp=1", done_total - d0); end
    endtask

    task automatic test_arbitration();
        do_reset();
        load_start = 1'b1; run_start = 1'b1;
        tick();
        load_start = 1'b0; run_start = 1'b0;
        checks++; if (load_busy !== 1'b1) begin failures++; $display("FAIL arb_busy got=%b exp=1", load_busy); end
        tick();
        checks++; if (cpu_reset_p !== 1'b1) begin failures++; $display("FAIL arb_cpu_reset got=%b exp=1", cpu_reset_p); end
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
        tick();
        checks++; if (load_busy !== 1'b1 || cpu_reset_p !== 1'b1) begin failures++; $display("FAIL arb_run_ignored busy=%b cpu=%b exp 1 1", load_busy, cpu_reset_p); end
    endtask

    task automatic test_reset_in_check();
        int bad;
        do_reset();
        start_load();
        send_prog();
        checks++; if (load_busy !== 1'b1) begin failures++; $display("FAIL rchk_in_check got=%b exp=1", load_busy); end
        reset_p = 1'b1;
        tick();
        reset_p = 1'b0;
        checks++; if (load_busy !== 1'b0 || rx_ready !== 1'b0) begin failures++; $display("FAIL rchk_idle busy=%b ready=%b exp 0 0", load_busy, rx_ready); end
        checks++; if (cpu_reset_p !== 1'b1) begin failures++; $display("FAIL rchk_cpu_reset got=%b exp=1", cpu_reset_p); end
        bad = 0;
        for (int a = 0; a < 16; a++) begin
            rom_addr = 4'(a); #1;
            if (rom_data !== 8'h00) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL rchk_mem_clear nonzero_words=%0d exp=0", bad); end
    endtask

    task automatic test_no_checksum();
        do_reset();
        start_load();
        send_prog();
        checks++; if (nc_load_done !== 1'b1 || nc_load_busy !== 1'b0) begin failures++; $display("FAIL nochk_done done=%b busy=%b exp 1 0", nc_load_done, nc_load_busy); end
        tick();
        checks++; if (nc_cpu_reset_p !== 1'b0) begin failures++; $display("FAIL nochk_cpu_release got=%b exp=0", nc_cpu_reset_p); end
        rom_addr = 4'd0; #1;
        checks++; if (nc_rom_data !== 8'h19) begin failures++; $display("FAIL nochk_rom0 got=%h exp=19", nc_rom_data); end
    endtask

    initial begin
        prog = '{default: 8'h00};
        prog[0] = 8'h19;
        prog[1] = 8'hF2;
        prog[2] = 8'h90;
        test_reset();
        test_good_load();
        test_bad_checksum();
        test_timeout();
        test_restart();
        test_arbitration();
        test_reset_in_check();
        test_no_checksum();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
